// File: rtl/salsa20_pkg.sv
// Shared constants and types for the iterative Salsa20 core engine:
// word geometry, FSM encoding, quarterround index tables and rotations.
package salsa20_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 16;
   localparam int STATE_W   = WORD_W * NUM_WORDS;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [3:0]        widx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } fsm_t;

   // Indexed [qr_ctr][operand]; operand k feeds quarterround input y_k.
   localparam widx_t COL_IDX [4][4] = '{
      '{4'd0,  4'd4,  4'd8,  4'd12},
      '{4'd5,  4'd9,  4'd13, 4'd1 },
      '{4'd10, 4'd14, 4'd2,  4'd6 },
      '{4'd15, 4'd3,  4'd7,  4'd11}
   };

   localparam widx_t ROW_IDX [4][4] = '{
      '{4'd0,  4'd1,  4'd2,  4'd3 },
      '{4'd5,  4'd6,  4'd7,  4'd4 },
      '{4'd10, 4'd11, 4'd8,  4'd9 },
      '{4'd15, 4'd12, 4'd13, 4'd14}
   };

   localparam int ROT_1 = 7;
   localparam int ROT_2 = 9;
   localparam int ROT_3 = 13;
   localparam int ROT_4 = 18;

   function automatic word_t rotl(input word_t v, input int n);
      return (v << n) | (v >> (WORD_W - n));
   endfunction

endpackage

// File: rtl/salsa20_qr.sv
// Combinational Salsa20 quarterround; every output is computed from the
// chained intermediate values so all four words update in one cycle.
module salsa20_qr
   import salsa20_pkg::*;
(
   input  logic [WORD_W-1:0] y0,
   input  logic [WORD_W-1:0] y1,
   input  logic [WORD_W-1:0] y2,
   input  logic [WORD_W-1:0] y3,
   output logic [WORD_W-1:0] z0,
   output logic [WORD_W-1:0] z1,
   output logic [WORD_W-1:0] z2,
   output logic [WORD_W-1:0] z3
);

   word_t sum1, sum2, sum3, sum4;

   always_comb begin
      sum1 = y0 + y3;
      z1   = y1 ^ rotl(sum1, ROT_1);
      sum2 = z1 + y0;
      z2   = y2 ^ rotl(sum2, ROT_2);
      sum3 = z2 + z1;
      z3   = y3 ^ rotl(sum3, ROT_3);
      sum4 = z3 + z2;
      z0   = y0 ^ rotl(sum4, ROT_4);
   end

endmodule

// File: rtl/salsa20_round_ctrl.sv
// Iterative Salsa20 core: one quarterround per cycle over a 16-word working
// state, then a feed-forward add of the saved input to form the result.
module salsa20_round_ctrl
   import salsa20_pkg::*;
#(
   parameter int ROUNDS = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [STATE_W-1:0] state_in,
   output logic               ready,
   output logic [STATE_W-1:0] data_out,
   output logic               data_out_valid
);

   localparam int RC_W = $clog2(ROUNDS);

   fsm_t                                state;
   logic [NUM_WORDS-1:0][WORD_W-1:0]    x;
   logic [NUM_WORDS-1:0][WORD_W-1:0]    s;
   logic [NUM_WORDS-1:0][WORD_W-1:0]    ff_sum;
   logic [1:0]                          qr_ctr;
   logic [RC_W-1:0]                     round_ctr;
   widx_t                               idx [4];
   word_t                               y   [4];
   word_t                               z   [4];

   // Odd rounds are row rounds; the same index drives operand mux and write-back.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         idx[k] = round_ctr[0] ? ROW_IDX[qr_ctr][k] : COL_IDX[qr_ctr][k];
         y[k]   = x[idx[k]];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_WORDS; i++) begin
         ff_sum[i] = x[i] + s[i];
      end
   end

   salsa20_qr u_qr (
      .y0 (y[0]),
      .y1 (y[1]),
      .y2 (y[2]),
      .y3 (y[3]),
      .z0 (z[0]),
      .z1 (z[1]),
      .z2 (z[2]),
      .z3 (z[3])
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         x              <= '0;
         s              <= '0;
         qr_ctr         <= '0;
         round_ctr      <= '0;
         ready          <= 1'b1;
         data_out_valid <= 1'b0;
         data_out       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x              <= state_in;
                  s              <= state_in;
                  qr_ctr         <= '0;
                  round_ctr      <= '0;
                  ready          <= 1'b0;
                  data_out_valid <= 1'b0;
                  state          <= ROUND;
               end
            end
            ROUND: begin
               x[idx[0]] <= z[0];
               x[idx[1]] <= z[1];
               x[idx[2]] <= z[2];
               x[idx[3]] <= z[3];
               qr_ctr    <= qr_ctr + 2'd1;
               if (qr_ctr == 2'd3) begin
                  if (round_ctr == RC_W'(ROUNDS - 1)) begin
                     state <= FINAL;
                  end else begin
                     round_ctr <= round_ctr + RC_W'(1);
                  end
               end
            end
            FINAL: begin
               data_out       <= ff_sum;
               data_out_valid <= 1'b1;
               ready          <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
